// File: rtl/coherence_controller_if.sv
// Signal bundle between the coherence controller, the two per-core L1 caches and the shared RAM port.
// The controller takes the slave view; whatever drives the caches and RAM takes the master view.
interface coherence_controller_if #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
);
  // icache side
  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0][WORD_W-1:0] iaddr;
  logic [CPUS-1:0][WORD_W-1:0] iload;
  logic [CPUS-1:0]             iwait;
  // dcache side
  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0][WORD_W-1:0] daddr;
  logic [CPUS-1:0][WORD_W-1:0] dstore;
  logic [CPUS-1:0]             cctrans;
  logic [CPUS-1:0]             ccwrite;
  logic [CPUS-1:0][WORD_W-1:0] dload;
  logic [CPUS-1:0]             dwait;
  logic [CPUS-1:0]             ccwait;
  logic [CPUS-1:0]             ccinv;
  logic [CPUS-1:0][WORD_W-1:0] ccsnoopaddr;
  // RAM side
  logic                        ramREN;
  logic                        ramWEN;
  logic [WORD_W-1:0]           ramaddr;
  logic [WORD_W-1:0]           ramstore;
  logic [WORD_W-1:0]           ramload;
  logic [1:0]                  ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_controller.sv
// Two-core bus/coherence controller: arbitrates ifetch, writeback and coherent misses onto one RAM port,
// runs the snoop handshake and services dirty-peer hits by cache-to-cache transfer written through to RAM.
module coherence_controller #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input logic                   CLK,
  input logic                   RST,
  coherence_controller_if.slave ccif
);

  typedef enum logic [3:0] {IDLE, IF, WB, SNP, SRSP, C2C1, C2C2, LD1, LD2} state_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ram_state_t;

  state_t state, state_n;
  logic   rr, rr_n;   // round-robin pointer for ties within one request class
  logic   g, g_n;     // granted core
  logic   s;          // snooper: with two cores, always the other one
  logic   access;

  logic [CPUS-1:0]             iwait_c, dwait_c, ccwait_c, ccinv_c;
  logic [CPUS-1:0][WORD_W-1:0] iload_c, dload_c, snoop_c;
  logic                        ram_ren_c, ram_wen_c;
  logic [WORD_W-1:0]           ram_addr_c, ram_store_c;

  assign s      = ~g;
  assign access = (ram_state_t'(ccif.ramstate) == ACCESS);

  // Both requesting -> rr decides; otherwise the lone requester wins.
  function automatic logic pick(input logic [CPUS-1:0] req, input logic ptr);
    return (req == 2'b11) ? ptr : req[1];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rr    <= 1'b0;
      g     <= 1'b0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      g     <= g_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_n     = state;
    rr_n        = rr;
    g_n         = g;
    iwait_c     = '1;
    dwait_c     = '1;
    iload_c     = '0;
    dload_c     = '0;
    ccwait_c    = '0;
    ccinv_c     = '0;
    snoop_c     = '0;
    ram_ren_c   = 1'b0;
    ram_wen_c   = 1'b0;
    ram_addr_c  = '0;
    ram_store_c = '0;

    if (state inside {SNP, SRSP, C2C1, C2C2}) begin
      ccwait_c[s] = 1'b1;
      snoop_c[s]  = ccif.daddr[g];
      ccinv_c[s]  = ccif.ccwrite[g];
    end

    case (state)
      IDLE: begin
        if (|ccif.dWEN) begin
          g_n     = pick(ccif.dWEN, rr);
          state_n = WB;
        end else if (|(ccif.dREN & ccif.cctrans)) begin
          g_n     = pick(ccif.dREN & ccif.cctrans, rr);
          state_n = SNP;
        end else if (|ccif.iREN) begin
          g_n     = pick(ccif.iREN, rr);
          state_n = IF;
        end
      end

      IF: begin
        ram_ren_c  = 1'b1;
        ram_addr_c = ccif.iaddr[g];
        iload_c[g] = ccif.ramload;
        if (access) begin
          iwait_c[g] = 1'b0;
          state_n    = IDLE;
        end
      end

      // The cache steps through its own block words; the bus stays granted until dWEN drops.
      WB: begin
        if (ccif.dWEN[g]) begin
          ram_wen_c   = 1'b1;
          ram_addr_c  = ccif.daddr[g];
          ram_store_c = ccif.dstore[g];
          if (access) dwait_c[g] = 1'b0;
        end else begin
          state_n = IDLE;
          rr_n    = ~rr;
        end
      end

      SNP: state_n = SRSP;

      SRSP: state_n = (ccif.cctrans[s] && ccif.ccwrite[s]) ? C2C1 : LD1;

      // Dirty peer supplies the word; it lands in the requester and in RAM on the same beat.
      C2C1, C2C2: begin
        ram_wen_c   = 1'b1;
        ram_addr_c  = ccif.daddr[s];
        ram_store_c = ccif.dstore[s];
        dload_c[g]  = ccif.dstore[s];
        if (access) begin
          dwait_c[s] = 1'b0;
          dwait_c[g] = 1'b0;
          if (state == C2C1 && ccif.dREN[g]) begin
            state_n = C2C2;
          end else begin
            state_n = IDLE;
            rr_n    = ~rr;
          end
        end
      end

      LD1, LD2: begin
        ram_ren_c  = 1'b1;
        ram_addr_c = ccif.daddr[g];
        dload_c[g] = ccif.ramload;
        if (access) begin
          dwait_c[g] = 1'b0;
          if (state == LD1 && ccif.dREN[g]) begin
            state_n = LD2;
          end else begin
            state_n = IDLE;
            rr_n    = ~rr;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign ccif.iwait       = iwait_c;
  assign ccif.iload       = iload_c;
  assign ccif.dwait       = dwait_c;
  assign ccif.dload       = dload_c;
  assign ccif.ccwait      = ccwait_c;
  assign ccif.ccinv       = ccinv_c;
  assign ccif.ccsnoopaddr = snoop_c;
  assign ccif.ramREN      = ram_ren_c;
  assign ccif.ramWEN      = ram_wen_c;
  assign ccif.ramaddr     = ram_addr_c;
  assign ccif.ramstore    = ram_store_c;

endmodule

// File: tb/tb_coherence_controller.sv
// Directed bench for coherence_controller: hand-computed vectors for ifetch, writeback, clean miss,
// cache-to-cache transfer, arbitration ties, RAM stalls/errors and reset mid-transaction.
module tb_coherence_controller;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  coherence_controller_if bus ();

  coherence_controller dut (
    .CLK  (CLK),
    .RST  (RST),
    .ccif (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.cctrans  = '0;
    bus.ccwrite  = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  // Hold a non-ACCESS RAM state for n cycles: strobe and address stay put, nobody released.
  task automatic ram_hold(input int n, input logic [1:0] st, input logic [31:0] addr, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.ramstate = st;
      #1;
      check({tag, "_dwait"}, 32'(bus.dwait), 32'h3);
      check({tag, "_iwait"}, 32'(bus.iwait), 32'h3);
      check({tag, "_ren"},   32'(bus.ramREN), 32'h1);
      check({tag, "_addr"},  bus.ramaddr, addr);
      cyc();
    end
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    #2;
    // Reset state
    check("rst_iwait",  32'(bus.iwait),  32'h3);
    check("rst_dwait",  32'(bus.dwait),  32'h3);
    check("rst_ccwait", 32'(bus.ccwait), 32'h0);
    check("rst_ccinv",  32'(bus.ccinv),  32'h0);
    check("rst_ren",    32'(bus.ramREN), 32'h0);
    check("rst_wen",    32'(bus.ramWEN), 32'h0);
    check("rst_addr",   bus.ramaddr,     32'h0);
    check("rst_store",  bus.ramstore,    32'h0);
    check("rst_snoop",  bus.ccsnoopaddr[1], 32'h0);
    cyc();
    RST = 1'b0;
    cyc();

    // Core0 coherent read miss 0x100, peer clean, 2 BUSY cycles before each ACCESS
    bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h100;
    #1;
    check("ld_idle_dwait", 32'(bus.dwait), 32'h3);
    cyc();                                                   // SNP
    check("ld_snp_ccwait", 32'(bus.ccwait), 32'h2);
    check("ld_snp_addr",   bus.ccsnoopaddr[1], 32'h100);
    check("ld_snp_inv",    32'(bus.ccinv), 32'h0);
    check("ld_snp_ren",    32'(bus.ramREN), 32'h0);
    cyc();                                                   // SRSP, peer does not claim dirty
    check("ld_srsp_ccwait", 32'(bus.ccwait), 32'h2);
    cyc();                                                   // LD1
    check("ld1_ccwait", 32'(bus.ccwait), 32'h0);
    ram_hold(2, BUSY, 32'h100, "ld1_busy");
    bus.ramstate = ACCESS; bus.ramload = 32'hAAAA_0100;
    #1;
    check("ld1_dwait", 32'(bus.dwait), 32'h2);
    check("ld1_dload", bus.dload[0], 32'hAAAA_0100);
    cyc();                                                   // LD2
    bus.daddr[0] = 32'h104;
    ram_hold(2, BUSY, 32'h104, "ld2_busy");
    bus.ramstate = ACCESS; bus.ramload = 32'hBBBB_0104;
    #1;
    check("ld2_dwait", 32'(bus.dwait), 32'h2);
    check("ld2_dload", bus.dload[0], 32'hBBBB_0104);
    cyc();                                                   // IDLE
    clear_inputs();
    #1;
    check("ld_done_ren", 32'(bus.ramREN), 32'h0);
    check("ld_done_rr",  32'(dut.rr), 32'h1);

    // Core1 read-for-write 0x200; core0 holds the block dirty -> cache-to-cache
    bus.dREN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h200;
    bus.daddr[0] = 32'h200; bus.dstore[0] = 32'hD0D0_0200;
    cyc();                                                   // SNP
    check("c2c_snp_inv",    32'(bus.ccinv),  32'h1);
    check("c2c_snp_ccwait", 32'(bus.ccwait), 32'h1);
    check("c2c_snp_addr",   bus.ccsnoopaddr[0], 32'h200);
    bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1;
    cyc();                                                   // SRSP
    check("c2c_srsp_inv", 32'(bus.ccinv), 32'h1);
    cyc();                                                   // C2C1
    bus.ramstate = BUSY;
    #1;
    check("c2c1_busy_dwait", 32'(bus.dwait), 32'h3);
    bus.ramstate = ACCESS;
    #1;
    check("c2c1_wen",   32'(bus.ramWEN), 32'h1);
    check("c2c1_addr",  bus.ramaddr,  32'h200);
    check("c2c1_store", bus.ramstore, 32'hD0D0_0200);
    check("c2c1_dload", bus.dload[1], 32'hD0D0_0200);
    check("c2c1_dwait", 32'(bus.dwait), 32'h0);
    cyc();                                                   // C2C2
    bus.daddr[0] = 32'h204; bus.daddr[1] = 32'h204; bus.dstore[0] = 32'hD0D0_0204;
    #1;
    check("c2c2_addr",   bus.ramaddr,  32'h204);
    check("c2c2_dload",  bus.dload[1], 32'hD0D0_0204);
    check("c2c2_ccwait", 32'(bus.ccwait), 32'h1);
    check("c2c2_dwait",  32'(bus.dwait), 32'h0);
    cyc();                                                   // IDLE
    clear_inputs();
    #1;
    check("c2c_done_ccwait", 32'(bus.ccwait), 32'h0);
    check("c2c_done_wen",    32'(bus.ramWEN), 32'h0);

    // Both cores write back in the same cycle with rr=0 -> core0 first
    bus.dWEN = 2'b11; bus.daddr[0] = 32'h300; bus.dstore[0] = 32'h0000_0300;
    bus.daddr[1] = 32'h400; bus.dstore[1] = 32'h0000_0400; bus.ramstate = ACCESS;
    cyc();                                                   // WB core0
    check("wb0_addr",  bus.ramaddr,  32'h300);
    check("wb0_store", bus.ramstore, 32'h0000_0300);
    check("wb0_dwait", 32'(bus.dwait), 32'h2);
    cyc();
    bus.daddr[0] = 32'h304;
    #1;
    check("wb0b_addr",  bus.ramaddr, 32'h304);
    check("wb0b_dwait", 32'(bus.dwait), 32'h2);
    cyc();
    bus.dWEN[0] = 1'b0;
    #1;
    check("wb0_exit_dwait", 32'(bus.dwait), 32'h3);
    check("wb0_exit_wen",   32'(bus.ramWEN), 32'h0);
    cyc();                                                   // IDLE
    check("wb_mid_rr",    32'(dut.rr), 32'h1);
    check("wb_mid_dwait", 32'(bus.dwait), 32'h3);
    cyc();                                                   // WB core1
    check("wb1_addr",  bus.ramaddr,  32'h400);
    check("wb1_store", bus.ramstore, 32'h0000_0400);
    check("wb1_dwait", 32'(bus.dwait), 32'h1);
    bus.dWEN[1] = 1'b0;
    cyc();                                                   // IDLE
    clear_inputs();
    cyc();

    // iREN and coherent miss of core0 together -> miss first, ifetch after LD2
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40;
    bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h500;
    bus.ramstate = ACCESS; bus.ramload = 32'h5555_0500;
    cyc();                                                   // SNP
    check("pri_snp_iwait", 32'(bus.iwait), 32'h3);
    cyc();                                                   // SRSP
    cyc();                                                   // LD1
    check("pri_ld1_iwait", 32'(bus.iwait), 32'h3);
    check("pri_ld1_dwait", 32'(bus.dwait), 32'h2);
    bus.daddr[0] = 32'h504;
    cyc();                                                   // LD2
    check("pri_ld2_iwait", 32'(bus.iwait), 32'h3);
    check("pri_ld2_addr",  bus.ramaddr, 32'h504);
    cyc();                                                   // IDLE
    bus.dREN[0] = 1'b0; bus.cctrans[0] = 1'b0;
    #1;
    check("pri_idle_iwait", 32'(bus.iwait), 32'h3);
    cyc();                                                   // IF
    bus.ramload = 32'h1234_0040;
    #1;
    check("if_iwait", 32'(bus.iwait), 32'h2);
    check("if_iload", bus.iload[0], 32'h1234_0040);
    check("if_addr",  bus.ramaddr, 32'h40);
    check("if_ren",   32'(bus.ramREN), 32'h1);
    cyc();
    clear_inputs();
    cyc();

    // ERROR for 10 cycles in LD1 (core1, rr=1), then resume; reset pulse mid-LD2
    bus.dREN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.daddr[1] = 32'h600;
    cyc();                                                   // SNP
    check("err_snp_ccwait", 32'(bus.ccwait), 32'h1);
    cyc();                                                   // SRSP
    cyc();                                                   // LD1
    ram_hold(10, ERROR, 32'h600, "ld1_err");
    bus.ramstate = ACCESS; bus.ramload = 32'h6666_0600;
    #1;
    check("err_ld1_dwait", 32'(bus.dwait), 32'h1);
    check("err_ld1_dload", bus.dload[1], 32'h6666_0600);
    cyc();                                                   // LD2
    bus.daddr[1] = 32'h604;
    #1;
    check("rst_ld2_ren", 32'(bus.ramREN), 32'h1);
    RST = 1'b1;
    #1;
    check("rst_async_ren",   32'(bus.ramREN), 32'h0);
    check("rst_async_dwait", 32'(bus.dwait),  32'h3);
    cyc();
    RST = 1'b0;
    #1;
    check("rst_post_ren",   32'(bus.ramREN), 32'h0);
    check("rst_post_dwait", 32'(bus.dwait),  32'h3);
    check("rst_post_rr",    32'(dut.rr),     32'h0);
    clear_inputs();
    cyc();

    // Requester drops dREN on the LD1 beat -> back to IDLE, no LD2
    bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h700; bus.ramstate = BUSY;
    cyc();                                                   // SNP
    cyc();                                                   // SRSP
    cyc();                                                   // LD1
    bus.dREN[0] = 1'b0; bus.cctrans[0] = 1'b0; bus.ramstate = ACCESS;
    #1;
    check("abort_ld1_ren", 32'(bus.ramREN), 32'h1);
    cyc();
    check("abort_idle_ren", 32'(bus.ramREN), 32'h0);
    check("abort_rr",       32'(dut.rr),     32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
